// File: rtl/mips_prog_loader.sv
// mips_prog_loader: streams a program image into core memory, then runs the core until it halts.
// Latency: an accepted word is written on the next cycle; cpu_run rises two cycles after the last accept.
// Backpressure: s_ready stays high for the whole LOAD phase (one word per cycle) and is low in every other state.
module mips_prog_loader #(
    parameter int          ADDR_W  = 10,
    parameter logic [5:0]  HLT_OPC = 6'h3f
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    input  logic              halted_in,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       run_cycles,
    output logic              err_overflow,
    output logic              err_no_hlt
);

    // Word count at which memory is full.
    localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_q;
    logic                s_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                cpu_run_q;
    logic                done_q;
    logic [ADDR_W:0]     word_count_q;
    logic [ADDR_W:0]     word_count_d;
    logic [31:0]         run_cycles_q;
    logic [31:0]         run_cycles_d;
    logic                err_overflow_q;
    logic                err_no_hlt_q;
    logic                hlt_seen_q;

    logic                accept;
    logic                room;
    logic                is_hlt;

    // Handshake decode and saturating counter next values.
    always_comb begin
        accept       = s_valid & s_ready_q;
        room         = (word_count_q < DEPTH_W);
        is_hlt       = (s_data[31:26] == HLT_OPC);
        word_count_d = word_count_q + 1'b1;
        run_cycles_d = (&run_cycles_q) ? run_cycles_q : run_cycles_q + 32'd1;
    end

    // Sequencer: load words, settle one cycle so the last write lands, run, then hold results.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q        <= IDLE;
            s_ready_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            cpu_run_q      <= 1'b0;
            done_q         <= 1'b0;
            word_count_q   <= '0;
            run_cycles_q   <= '0;
            err_overflow_q <= 1'b0;
            err_no_hlt_q   <= 1'b0;
            hlt_seen_q     <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted word.
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q        <= LOAD;
                        s_ready_q      <= 1'b1;
                        done_q         <= 1'b0;
                        word_count_q   <= '0;
                        run_cycles_q   <= '0;
                        err_overflow_q <= 1'b0;
                        err_no_hlt_q   <= 1'b0;
                        hlt_seen_q     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (room) begin
                            mem_we_q     <= 1'b1;
                            mem_addr_q   <= word_count_q[ADDR_W-1:0];
                            mem_wdata_q  <= s_data;
                            word_count_q <= word_count_d;
                            if (is_hlt) begin
                                hlt_seen_q <= 1'b1;
                            end
                        end else begin
                            // Memory full: drop the word, count stays saturated.
                            err_overflow_q <= 1'b1;
                        end
                        if (s_last) begin
                            s_ready_q <= 1'b0;
                            if (!hlt_seen_q && !is_hlt) begin
                                err_no_hlt_q <= 1'b1;
                            end
                            // A truncated image is never executed.
                            if (!room || err_overflow_q) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= SETTLE;
                            end
                        end
                    end
                end
                SETTLE: begin
                    state_q   <= RUN;
                    cpu_run_q <= 1'b1;
                end
                RUN: begin
                    run_cycles_q <= run_cycles_d;
                    if (halted_in) begin
                        state_q   <= DONE;
                        cpu_run_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign done         = done_q;
    assign word_count   = word_count_q;
    assign run_cycles   = run_cycles_q;
    assign err_overflow = err_overflow_q;
    assign err_no_hlt   = err_no_hlt_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: a default-depth instance and a 4-word instance share one stimulus stream.
// Expected values are hand-derived from the loader's cycle behaviour.
// Memory writes are logged on the falling edge and compared against the image afterwards.
module tb_mips_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        halted_in = 1'b0;

    // Default-depth instance outputs
    logic        s_ready, mem_we, cpu_run, done, err_overflow, err_no_hlt;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, run_cycles;
    logic [10:0] word_count;

    // ADDR_W=2 instance outputs
    logic        b_s_ready, b_mem_we, b_cpu_run, b_done, b_err_overflow, b_err_no_hlt;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_run_cycles;
    logic [2:0]  b_word_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] bq_addr[$];
    logic [31:0] bq_data[$];
    int          b_run_cnt = 0;

    logic [31:0] img[9];

    mips_prog_loader #(.ADDR_W(10), .HLT_OPC(6'h3f)) u0 (
        .clk1(clk1), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_run(cpu_run), .halted_in(halted_in), .done(done),
        .word_count(word_count), .run_cycles(run_cycles), .err_overflow(err_overflow),
        .err_no_hlt(err_no_hlt)
    );

    mips_prog_loader #(.ADDR_W(2), .HLT_OPC(6'h3f)) u1 (
        .clk1(clk1), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_data(s_data), .s_last(s_last), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .cpu_run(b_cpu_run), .halted_in(halted_in), .done(b_done),
        .word_count(b_word_count), .run_cycles(b_run_cycles), .err_overflow(b_err_overflow),
        .err_no_hlt(b_err_no_hlt)
    );

    always #5 clk1 = ~clk1;

    // Log every memory write and count cpu_run cycles of the small instance.
    always @(negedge clk1) begin
        if (mem_we) begin
            wq_addr.push_back(32'(mem_addr));
            wq_data.push_back(mem_wdata);
        end
        if (b_mem_we) begin
            bq_addr.push_back(32'(b_mem_addr));
            bq_data.push_back(b_mem_wdata);
        end
        if (b_cpu_run) b_run_cnt <= b_run_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one word after 'gap' idle cycles and hold it until accepted.
    task automatic push(input logic [31:0] w, input logic last, input int gap);
        int n;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = w;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("s_ready_timeout", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic push_image(input int gap);
        for (int i = 0; i < 9; i++) push(img[i], (i == 8), gap);
    endtask

    task automatic chk_image(input string tag, input int base);
        chk({tag, "_nwrites"}, 32'(wq_addr.size() - base), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (base + i < wq_addr.size()) begin
                chk({tag, "_addr"}, wq_addr[base + i], 32'(i));
                chk({tag, "_data"}, wq_data[base + i], img[i]);
            end
        end
    endtask

    // From the first RUN cycle, raise halted_in during the n-th RUN cycle.
    task automatic halt_after(input int n);
        repeat (n - 1) tick();
        halted_in = 1'b1;
        tick();
        halted_in = 1'b0;
    endtask

    initial begin
        int base;
        int bbase;
        int brun0;

        img[0] = 32'h2801000a; img[1] = 32'h28010014; img[2] = 32'h28010019;
        img[3] = 32'h0ce77800; img[4] = 32'h0ce77800; img[5] = 32'h00222000;
        img[6] = 32'h0ce77800; img[7] = 32'h00832800; img[8] = 32'hfc000000;

        // Reset values
        rst = 1'b1;
        tick(); tick();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_run", 32'(cpu_run), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        chk("rst_err_ovf", 32'(err_overflow), 32'd0);
        chk("rst_err_nohlt", 32'(err_no_hlt), 32'd0);
        chk("rst_b_s_ready", 32'(b_s_ready), 32'd0);
        rst = 1'b0;
        tick();

        // Overflow on the 4-word instance: 6 words, last is HLT
        bbase = bq_addr.size();
        brun0 = b_run_cnt;
        base  = wq_addr.size();
        pulse_start();
        chk("ovf_s_ready_rise", 32'(b_s_ready), 32'd1);
        for (int i = 0; i < 6; i++) push((i == 5) ? 32'hfc000000 : 32'(i + 1), (i == 5), 0);
        chk("ovf_done", 32'(b_done), 32'd1);
        chk("ovf_err_ovf", 32'(b_err_overflow), 32'd1);
        chk("ovf_err_nohlt", 32'(b_err_no_hlt), 32'd0);
        chk("ovf_word_count", 32'(b_word_count), 32'd4);
        chk("ovf_s_ready_low", 32'(b_s_ready), 32'd0);
        // u0 (large) took the same 6 words and is now in SETTLE
        tick();
        chk("big6_cpu_run", 32'(cpu_run), 32'd1);
        halt_after(3);
        chk("big6_done", 32'(done), 32'd1);
        chk("big6_run_cycles", run_cycles, 32'd3);
        chk("big6_nwrites", 32'(wq_addr.size() - base), 32'd6);
        tick(); tick();
        chk("ovf_nwrites", 32'(bq_addr.size() - bbase), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (bbase + i < bq_addr.size()) begin
                chk("ovf_addr", bq_addr[bbase + i], 32'(i));
                chk("ovf_data", bq_data[bbase + i], 32'(i + 1));
            end
        end
        chk("ovf_cpu_run_never", 32'(b_run_cnt - brun0), 32'd0);
        chk("ovf_word_count_hold", 32'(b_word_count), 32'd4);

        // Continuous 9-word image
        base = wq_addr.size();
        pulse_start();
        chk("a_s_ready_rise", 32'(s_ready), 32'd1);
        chk("a_done_clr", 32'(done), 32'd0);
        chk("a_run_cycles_clr", run_cycles, 32'd0);
        push_image(0);
        // Edge N was the last accept: SETTLE cycle carries the last write
        chk("a_settle_s_ready", 32'(s_ready), 32'd0);
        chk("a_settle_cpu_run", 32'(cpu_run), 32'd0);
        chk("a_settle_mem_we", 32'(mem_we), 32'd1);
        chk("a_settle_mem_addr", 32'(mem_addr), 32'd8);
        chk("a_settle_wdata", mem_wdata, 32'hfc000000);
        chk("a_word_count", 32'(word_count), 32'd9);
        tick();
        chk("a_run_cpu_run", 32'(cpu_run), 32'd1);
        chk("a_run_mem_we", 32'(mem_we), 32'd0);
        chk("a_run_cycles0", run_cycles, 32'd0);
        chk_image("a", base);
        chk("a_err_ovf", 32'(err_overflow), 32'd0);
        chk("a_err_nohlt", 32'(err_no_hlt), 32'd0);
        // Halt during the 40th RUN cycle
        halt_after(40);
        chk("a_halt_done", 32'(done), 32'd1);
        chk("a_halt_cpu_run", 32'(cpu_run), 32'd0);
        chk("a_halt_run_cycles", run_cycles, 32'd40);
        for (int i = 0; i < 4; i++) begin
            halted_in = ~halted_in;
            tick();
        end
        halted_in = 1'b0;
        chk("a_ign_done", 32'(done), 32'd1);
        chk("a_ign_run_cycles", run_cycles, 32'd40);
        chk("a_ign_cpu_run", 32'(cpu_run), 32'd0);
        chk("a_ign_word_count", 32'(word_count), 32'd9);

        // Same image, s_valid toggled every other cycle
        base = wq_addr.size();
        pulse_start();
        chk("b_run_cycles_clr", run_cycles, 32'd0);
        chk("b_word_count_clr", 32'(word_count), 32'd0);
        push_image(1);
        chk("b_word_count", 32'(word_count), 32'd9);
        tick();
        chk("b_cpu_run", 32'(cpu_run), 32'd1);
        chk_image("b", base);
        halt_after(5);
        chk("b_run_cycles", run_cycles, 32'd5);

        // Image with no halt opcode
        pulse_start();
        push(32'h11111111, 1'b0, 0);
        push(32'h22222222, 1'b0, 0);
        push(32'h33333333, 1'b1, 0);
        chk("c_err_nohlt", 32'(err_no_hlt), 32'd1);
        chk("c_err_ovf", 32'(err_overflow), 32'd0);
        tick();
        chk("c_cpu_run", 32'(cpu_run), 32'd1);
        halt_after(2);
        chk("c_done", 32'(done), 32'd1);
        chk("c_word_count", 32'(word_count), 32'd3);

        // Reset mid-load with a word pending
        pulse_start();
        push(32'h0000aaaa, 1'b0, 0);
        push(32'h0000bbbb, 1'b0, 0);
        s_valid = 1'b1;
        s_data  = 32'h0000cccc;
        rst     = 1'b1;
        tick();
        chk("d_rst_s_ready", 32'(s_ready), 32'd0);
        chk("d_rst_mem_we", 32'(mem_we), 32'd0);
        chk("d_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("d_rst_wdata", mem_wdata, 32'd0);
        chk("d_rst_word_count", 32'(word_count), 32'd0);
        chk("d_rst_run_cycles", run_cycles, 32'd0);
        chk("d_rst_done", 32'(done), 32'd0);
        chk("d_rst_err_nohlt", 32'(err_no_hlt), 32'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        tick();
        base = wq_addr.size();
        pulse_start();
        push(32'hfc000000, 1'b1, 0);
        tick();
        chk("d_word_count", 32'(word_count), 32'd1);
        chk("d_nwrites", 32'(wq_addr.size() - base), 32'd1);
        if (base < wq_addr.size()) begin
            chk("d_addr", wq_addr[base], 32'd0);
            chk("d_data", wq_data[base], 32'hfc000000);
        end
        chk("d_err_nohlt", 32'(err_no_hlt), 32'd0);
        chk("d_cpu_run", 32'(cpu_run), 32'd1);
        halt_after(1);
        chk("d_run_cycles", run_cycles, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
